// File: rtl/bcd_sched_pkg.sv
// rtl/bcd_sched_pkg.sv - shared types and constants for the BCD conversion scheduler
// Purpose: state encoding, requester id type and sizing constants used by
//          bcd_serial_core, bcd_convert_scheduler and its interface.
package bcd_sched_pkg;

  localparam int WIDTH     = 23;        // binary input width
  localparam int DIGITS    = 7;         // BCD digits produced
  localparam int ITER_LAST = 22;        // index of the final shift iteration
  localparam int CNT_W     = 5;         // iteration counter width (holds 0..23)
  localparam int ACC_W     = DIGITS * 4;
  localparam logic [3:0] BLANK = 4'hF;  // blank code for the 7-segment driver

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/bcd_convert_scheduler_if.sv
// rtl/bcd_convert_scheduler_if.sv - requester/result bundle of the BCD conversion scheduler
// Purpose: groups the two-requester handshake and the result bus.
// Ports (signals):
//   req[1:0]     request levels, bit0 = A, bit1 = B
//   value_a/b    binary values of A and B
//   ack[1:0]     one-cycle capture acknowledge
//   busy         conversion in progress
//   done         one-cycle result-valid pulse
//   done_id      requester of the latest result (0 = A, 1 = B)
//   q_1..q_7     BCD digits, q_1 = units
// Modports: master = requester side, slave = scheduler side.
interface bcd_convert_scheduler_if;
  import bcd_sched_pkg::*;

  logic [1:0]       req;
  logic [WIDTH-1:0] value_a;
  logic [WIDTH-1:0] value_b;
  logic [1:0]       ack;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [3:0]       q_1, q_2, q_3, q_4, q_5, q_6, q_7;

  modport master (
    output req, value_a, value_b,
    input  ack, busy, done, done_id, q_1, q_2, q_3, q_4, q_5, q_6, q_7
  );

  modport slave (
    input  req, value_a, value_b,
    output ack, busy, done, done_id, q_1, q_2, q_3, q_4, q_5, q_6, q_7
  );

endinterface

// File: rtl/bcd_serial_core.sv
// rtl/bcd_serial_core.sv - serial double-dabble datapath, one iteration per step
// Purpose: holds the BCD accumulator, binary shift register and iteration counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_value, clear accumulator and counter
//   load_value   binary value to convert
//   step         perform one add-3 / shift iteration
//   acc          current BCD accumulator (digit 0 in bits 3:0)
//   last         counter is at the final iteration
module bcd_serial_core
  import bcd_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  output logic [ACC_W-1:0] acc,
  output logic             last
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] adj;

  // A digit of 5 or more becomes >= 10 after doubling, so it is pre-corrected
  // by +3 to make the shift produce a decimal carry into the next digit.
  always_comb begin
    adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[d*4 +: 4] > 4'd4) begin
        adj[d*4 +: 4] = acc_q[d*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    acc_d  = acc_q;
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      acc_d  = '0;
      sreg_d = load_value;
      cnt_d  = '0;
    end else if (step) begin
      // The top digit's carry-out falls off; the input range never needs it.
      {acc_d, sreg_d} = {adj, sreg_q} << 1;
      cnt_d           = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(ITER_LAST));

endmodule

// File: rtl/bcd_convert_scheduler.sv
// rtl/bcd_convert_scheduler.sv - round-robin shared binary-to-BCD conversion engine
// Purpose: arbitrates two requesters, runs a 23-iteration serial conversion and
//          registers seven BCD digits with a done pulse and the served id.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          bcd_convert_scheduler_if.slave (req/value/ack/busy/done/done_id/q_1..q_7)
// Build option: BCD_LEADING_BLANK_EN - leading zero digits (q_7..q_2) become 4'hF.
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_convert_scheduler_if.slave   bus
);

  state_t           state_q, state_d;
  req_id_t          ptr_q, ptr_d;     // last-served requester
  req_id_t          id_q, id_d;       // requester of the running conversion
  logic [1:0]       ack_q, ack_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [ACC_W-1:0] q_q, q_d;

  logic             core_load;
  logic             core_step;
  logic [ACC_W-1:0] core_acc;
  logic             core_last;
  logic [ACC_W-1:0] result;
  req_id_t          grant_id;
  logic [WIDTH-1:0] grant_value;

  bcd_serial_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (core_load),
    .load_value (grant_value),
    .step       (core_step),
    .acc        (core_acc),
    .last       (core_last)
  );

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_id = REQ_A;
    case (bus.req)
      2'b10:   grant_id = REQ_B;
      2'b11:   grant_id = (ptr_q == REQ_B) ? REQ_A : REQ_B;
      default: grant_id = REQ_A;
    endcase
    grant_value = (grant_id == REQ_B) ? bus.value_b : bus.value_a;
  end

`ifdef BCD_LEADING_BLANK_EN
  // Blank every zero digit above the most significant non-zero one; units stay.
  always_comb begin
    logic leading;
    result  = core_acc;
    leading = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (leading && (core_acc[d*4 +: 4] == 4'd0)) begin
        result[d*4 +: 4] = BLANK;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  always_comb begin
    result = core_acc;
  end
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    ack_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    q_d       = q_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          core_load = 1'b1;
          id_d      = grant_id;
          ack_d     = (grant_id == REQ_B) ? 2'b10 : 2'b01;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        q_d       = result;
        done_d    = 1'b1;
        done_id_d = (id_q == REQ_B);
        ptr_d     = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= REQ_B;
      id_q      <= REQ_A;
      ack_q     <= 2'b00;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      q_q       <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      q_q       <= q_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.q_1     = q_q[3:0];
  assign bus.q_2     = q_q[7:4];
  assign bus.q_3     = q_q[11:8];
  assign bus.q_4     = q_q[15:12];
  assign bus.q_5     = q_q[19:16];
  assign bus.q_6     = q_q[23:20];
  assign bus.q_7     = q_q[27:24];

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb/tb_bcd_convert_scheduler.sv - self-checking bench for bcd_convert_scheduler
module tb_bcd_convert_scheduler;
  import bcd_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_convert_scheduler_if bus();

  bcd_convert_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [27:0] q_all;
  assign q_all = {bus.q_7, bus.q_6, bus.q_5, bus.q_4, bus.q_3, bus.q_2, bus.q_1};

  typedef struct {
    logic [1:0]  r;
    logic [22:0] va;
    logic [22:0] vb;
    logic [1:0]  exp_ack;
    logic        exp_id;
    logic [27:0] exp_bcd;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] blank_of(input logic [27:0] b);
    logic [27:0] r;
    r = b;
`ifdef BCD_LEADING_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int d = 6; d >= 1; d--) begin
        if (lead && (r[d*4 +: 4] == 4'h0)) r[d*4 +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  task automatic wait_ack(input string name, output logic [1:0] a, output int c);
    logic seen;
    seen = 1'b0;
    a = 2'b00;
    c = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        a = bus.ack;
        c = cyc;
        seen = 1'b1;
      end
    end
    if (!seen) chk({name, "_ack_timeout"}, 0, 1);
  endtask

  // Waits for done; counts ack pulses and busy-low cycles seen before it.
  task automatic wait_done(input string name, output int c, output int acks, output int busy_low);
    logic seen;
    seen = 1'b0;
    c = 0;
    acks = 0;
    busy_low = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        c = cyc;
        seen = 1'b1;
      end else begin
        if (bus.ack != 2'b00) acks++;
        if (bus.busy !== 1'b1) busy_low++;
      end
    end
    if (!seen) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic convert(input string name, input logic [1:0] r, input logic [22:0] va,
                         input logic [22:0] vb, input logic [1:0] exp_ack,
                         input logic exp_id, input logic [27:0] exp_bcd);
    logic [1:0] a;
    int c_set, c0, c1, acks, bl;
    bus.value_a = va;
    bus.value_b = vb;
    bus.req     = r;
    c_set       = cyc;
    wait_ack(name, a, c0);
    bus.req = 2'b00;
    chk({name, "_ack"}, a, exp_ack);
    chk({name, "_ack_lat"}, c0 - c_set, 1);
    wait_done(name, c1, acks, bl);
    chk({name, "_lat"}, c1 - c0, 24);
    chk({name, "_busy_low"}, bl, 0);
    chk({name, "_extra_ack"}, acks, 0);
    chk({name, "_busy_at_done"}, bus.busy, 0);
    chk({name, "_q"}, q_all, blank_of(exp_bcd));
    chk({name, "_id"}, bus.done_id, exp_id);
    @(negedge clk);
    chk({name, "_done_pulse"}, bus.done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] a;
    int c0, c1, c2, acks, bl, dones;

    vt[0] = '{2'b01, 23'd8388607, 23'd0,       2'b01, 1'b0, 28'h8388607};
    vt[1] = '{2'b10, 23'd0,       23'd59,      2'b10, 1'b1, 28'h0000059};
    vt[2] = '{2'b01, 23'd1000,    23'd0,       2'b01, 1'b0, 28'h0001000};
    vt[3] = '{2'b01, 23'd0,       23'd0,       2'b01, 1'b0, 28'h0000000};
    vt[4] = '{2'b10, 23'd0,       23'd123456,  2'b10, 1'b1, 28'h0123456};
    vt[5] = '{2'b01, 23'd5,       23'd0,       2'b01, 1'b0, 28'h0000005};
    vt[6] = '{2'b10, 23'd0,       23'd4194304, 2'b10, 1'b1, 28'h4194304};
    vt[7] = '{2'b01, 23'd999999,  23'd0,       2'b01, 1'b0, 28'h0999999};
    vt[8] = '{2'b10, 23'd0,       23'd10,      2'b10, 1'b1, 28'h0000010};
    vt[9] = '{2'b01, 23'd1,       23'd0,       2'b01, 1'b0, 28'h0000001};

    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.value_a = '0;
    bus.value_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_done_id", bus.done_id, 0);
    chk("rst_q", q_all, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      convert($sformatf("v%0d", i), vt[i].r, vt[i].va, vt[i].vb,
              vt[i].exp_ack, vt[i].exp_id, vt[i].exp_bcd);
    end

    // Both requesting as reset releases: A first, B captured at E25.
    do_reset();
    bus.value_a = 23'd1000;
    bus.value_b = 23'd59;
    rst_n = 1'b1;
    bus.req = 2'b11;
    c2 = cyc;
    wait_ack("tie", a, c0);
    chk("tie_first_ack", a, 2'b01);
    chk("tie_first_lat", c0 - c2, 1);
    bus.req = 2'b10;
    wait_done("tie_a", c1, acks, bl);
    chk("tie_a_lat", c1 - c0, 24);
    chk("tie_a_q", q_all, blank_of(28'h0001000));
    chk("tie_a_id", bus.done_id, 0);
    wait_ack("tie_b", a, c2);
    chk("tie_b_ack", a, 2'b10);
    chk("tie_b_capture", c2 - c0, 25);
    bus.req = 2'b00;
    wait_done("tie_b", c1, acks, bl);
    chk("tie_b_q", q_all, blank_of(28'h0000059));
    chk("tie_b_id", bus.done_id, 1);

    // Alternation A, B, A with B holding req across its own done.
    do_reset();
    bus.value_a = 23'd111;
    bus.value_b = 23'd222;
    rst_n = 1'b1;
    bus.req = 2'b11;
    wait_ack("alt1", a, c0);
    chk("alt1_ack", a, 2'b01);
    bus.req = 2'b10;
    repeat (5) @(negedge clk);
    bus.req = 2'b11;
    wait_done("alt1", c1, acks, bl);
    chk("alt1_q", q_all, blank_of(28'h0000111));
    wait_ack("alt2", a, c0);
    chk("alt2_ack", a, 2'b10);
    wait_done("alt2", c1, acks, bl);
    chk("alt2_extra_ack", acks, 0);
    chk("alt2_q", q_all, blank_of(28'h0000222));
    chk("alt2_id", bus.done_id, 1);
    wait_ack("alt3", a, c0);
    chk("alt3_ack", a, 2'b01);
    bus.req = 2'b00;
    wait_done("alt3", c1, acks, bl);
    chk("alt3_q", q_all, blank_of(28'h0000111));
    chk("alt3_id", bus.done_id, 0);

    // Reset mid-conversion of 123456, around iteration 10.
    @(negedge clk);
    bus.value_a = 23'd123456;
    bus.req = 2'b01;
    wait_ack("mid", a, c0);
    bus.req = 2'b00;
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_done_id", bus.done_id, 0);
    chk("mid_rst_q", q_all, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    chk("mid_no_done", dones, 0);
    convert("mid_after", 2'b01, 23'd123456, 23'd0, 2'b01, 1'b0, 28'h0123456);

    // Requests raised during SHIFT and DONE are ignored.
    bus.value_a = 23'd4321;
    bus.value_b = 23'd77;
    bus.req = 2'b01;
    wait_ack("ign", a, c0);
    bus.req = 2'b00;
    acks = 0;
    bl = 0;
    c1 = 0;
    for (int i = 0; i < 40 && c1 == 0; i++) begin
      @(negedge clk);
      if (bus.done) c1 = cyc;
      else begin
        if (bus.ack != 2'b00) acks++;
        if (bus.busy !== 1'b1) bl++;
      end
      if (cyc == c0 + 5)  bus.req = 2'b10;
      if (cyc == c0 + 6)  bus.req = 2'b00;
      if (cyc == c0 + 23) bus.req = 2'b10;
      if (cyc == c0 + 24) bus.req = 2'b00;
    end
    chk("ign_lat", c1 - c0, 24);
    chk("ign_busy_low", bl, 0);
    chk("ign_q", q_all, blank_of(28'h0004321));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ack != 2'b00 || bus.busy) acks++;
    end
    chk("ign_no_grant", acks, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
